// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the 8-point FFT serial/parallel stages.
package fft_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int N_PTS      = 8;
  localparam int CNT_W      = 3;

  typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/fft_p2s_bank.sv
// One frame of storage: parallel write, bulk copy from another bank, indexed read.
module fft_p2s_bank
  import fft_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_we,
  input  logic [N_PTS-1:0][DW-1:0]   i_wdata,
  input  logic                       i_copy,
  input  logic [N_PTS-1:0][DW-1:0]   i_copyData,
  input  logic [CNT_W-1:0]           i_ridx,
  output logic [DW-1:0]              o_rdata,
  output logic [N_PTS-1:0][DW-1:0]   o_words
);

  logic [N_PTS-1:0][DW-1:0] r_mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem <= '0;
    end else if (i_copy) begin
      r_mem <= i_copyData;
    end else if (i_we) begin
      r_mem <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];
  assign o_words = r_mem;

endmodule

// File: rtl/fft_p2s.sv
// FFT output stage: double-buffered parallel-to-serial converter, word 0 first.
module fft_p2s
  import fft_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [DW-1:0] p_in0,
  input  logic [DW-1:0] p_in1,
  input  logic [DW-1:0] p_in2,
  input  logic [DW-1:0] p_in3,
  input  logic [DW-1:0] p_in4,
  input  logic [DW-1:0] p_in5,
  input  logic [DW-1:0] p_in6,
  input  logic [DW-1:0] p_in7,
  output logic          load_rdy,
  input  logic          out_en,
  output logic [DW-1:0] s_out,
  output logic          s_valid,
  output logic          s_last,
  output logic          ovf
);

  state_t                   r_state, w_nextState;
  logic [CNT_W-1:0]         r_cnt, w_nextCnt;
  logic                     r_shadowFull, w_nextShadowFull;
  logic                     r_ovf;
  logic                     w_accept, w_xfer, w_lastXfer;
  logic                     w_actWe, w_actCopy, w_shWe;
  logic [N_PTS-1:0][DW-1:0] w_pIn, w_shadowWords, w_activeWords;
  logic [DW-1:0]            w_activeRdata, w_shadowRdata;
  logic                     w_unusedBits;

  assign w_pIn      = {p_in7, p_in6, p_in5, p_in4, p_in3, p_in2, p_in1, p_in0};
  assign load_rdy   = !r_shadowFull;
  assign w_accept   = load && load_rdy;
  assign w_xfer     = (r_state == SHIFT) && out_en;
  assign w_lastXfer = w_xfer && (r_cnt == CNT_W'(N_PTS - 1));

  fft_p2s_bank #(.DW(DW)) u_active (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_we       (w_actWe),
    .i_wdata    (w_pIn),
    .i_copy     (w_actCopy),
    .i_copyData (w_shadowWords),
    .i_ridx     (r_cnt),
    .o_rdata    (w_activeRdata),
    .o_words    (w_activeWords)
  );

  fft_p2s_bank #(.DW(DW)) u_shadow (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_we       (w_shWe),
    .i_wdata    (w_pIn),
    .i_copy     (1'b0),
    .i_copyData ('0),
    .i_ridx     (r_cnt),
    .o_rdata    (w_shadowRdata),
    .o_words    (w_shadowWords)
  );

  // Each bank exposes both read styles; only one of each is consumed here.
  assign w_unusedBits = ^{w_activeWords, w_shadowRdata};

  always_comb begin
    w_nextState      = r_state;
    w_nextCnt        = r_cnt;
    w_nextShadowFull = r_shadowFull;
    w_actWe          = 1'b0;
    w_actCopy        = 1'b0;
    w_shWe           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_actWe     = 1'b1;
          w_nextCnt   = '0;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        // Last word frees the active bank: refill from shadow, else direct load, else idle.
        if (w_lastXfer) begin
          w_nextCnt = '0;
          if (r_shadowFull) begin
            w_actCopy        = 1'b1;
            w_nextShadowFull = 1'b0;
          end else if (w_accept) begin
            w_actWe = 1'b1;
          end else begin
            w_nextState = IDLE;
          end
        end else begin
          if (w_xfer) begin
            w_nextCnt = r_cnt + CNT_W'(1);
          end
          if (w_accept) begin
            w_shWe           = 1'b1;
            w_nextShadowFull = 1'b1;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shadowFull <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_cnt        <= w_nextCnt;
      r_shadowFull <= w_nextShadowFull;
      if (load && !load_rdy) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign s_valid = (r_state == SHIFT);
  assign s_out   = s_valid ? w_activeRdata : '0;
  assign s_last  = s_valid && (r_cnt == CNT_W'(N_PTS - 1));
  assign ovf     = r_ovf;

endmodule
